// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, stalling memory states on mem_ready.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCSource,
  output logic               OldPCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       old_pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  state_e state_q;
  state_e state_d;
  ctl_t   ctl_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control decode; outputs are Moore except the mem_ready-qualified ones.
  always_comb begin
    state_d = S_FETCH;
    ctl_c   = '0;
    case (state_q)
      S_FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.alu_src_b = 2'd1;
        if (mem_ready) begin
          ctl_c.ir_write     = 1'b1;
          ctl_c.pc_write     = 1'b1;
          ctl_c.old_pc_write = 1'b1;
          state_d            = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ctl_c.alu_src_a = 2'd2;
        ctl_c.alu_src_b = 2'd2;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        ctl_c.alu_src_a = 2'd1;
        ctl_c.alu_src_b = 2'd2;
        state_d         = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ctl_c.mem_read = 1'b1;
        ctl_c.iord     = 1'b1;
        state_d        = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 2'd1;
        ctl_c.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctl_c.mem_write  = 1'b1;
        ctl_c.iord       = 1'b1;
        ctl_c.instr_done = mem_ready;
        state_d          = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        ctl_c.alu_src_a = 2'd1;
        ctl_c.alu_op    = 2'b10;
        state_d         = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctl_c.alu_src_a = 2'd1;
        ctl_c.alu_src_b = 2'd2;
        ctl_c.alu_op    = 2'b10;
        state_d         = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctl_c.pc_write_cond = 1'b1;
        ctl_c.pc_source     = 1'b1;
        ctl_c.alu_src_a     = 2'd1;
        ctl_c.alu_op        = 2'b01;
        ctl_c.instr_done    = 1'b1;
      end
      S_JAL: begin
        ctl_c.pc_write   = 1'b1;
        ctl_c.pc_source  = 1'b1;
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 2'd2;
        ctl_c.instr_done = 1'b1;
      end
      S_ILLEGAL: ctl_c.illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset blanks every enable and select immediately, even mid-instruction.
  always_comb begin
    PCWrite       = ctl_c.pc_write      & ~reset;
    PCWriteCond   = ctl_c.pc_write_cond & ~reset;
    PCSource      = ctl_c.pc_source     & ~reset;
    OldPCWrite    = ctl_c.old_pc_write  & ~reset;
    IorD          = ctl_c.iord          & ~reset;
    MemRead       = ctl_c.mem_read      & ~reset;
    MemWrite      = ctl_c.mem_write     & ~reset;
    IRWrite       = ctl_c.ir_write      & ~reset;
    RegWrite      = ctl_c.reg_write     & ~reset;
    MemtoReg      = reset ? 2'd0 : ctl_c.mem_to_reg;
    ALUSrcA       = reset ? 2'd0 : ctl_c.alu_src_a;
    ALUSrcB       = reset ? 2'd0 : ctl_c.alu_src_b;
    ALUOp         = reset ? 2'd0 : ctl_c.alu_op;
    instr_done    = ctl_c.instr_done    & ~reset;
    illegal_instr = ctl_c.illegal       & ~reset;
  end

  assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed test-plan sequences
// followed by randomized instruction streams with random memory stalls.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       old_pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       ctl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, PCSource, OldPCWrite, IorD, MemRead, MemWrite;
  logic       IRWrite, RegWrite, instr_done, illegal_instr;
  logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state_dbg;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_done = 0, act_done = 0, exp_ill = 0, act_ill = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .OldPCWrite(OldPCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Control word each named step of an instruction is documented to present.
  function automatic ctl_t exp_ctl(input int st, input bit rdy);
    ctl_t c = '0;
    case (st)
      0: begin
        c.mem_read = 1; c.alu_src_b = 2'd1;
        if (rdy) begin c.ir_write = 1; c.pc_write = 1; c.old_pc_write = 1; end
      end
      1: begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd2; end
      2: begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; end
      3: begin c.mem_read = 1; c.iord = 1; end
      4: begin c.reg_write = 1; c.mem_to_reg = 2'd1; c.instr_done = 1; end
      5: begin c.mem_write = 1; c.iord = 1; c.instr_done = rdy; end
      6: begin c.alu_src_a = 2'd1; c.alu_op = 2'b10; end
      7: begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.alu_op = 2'b10; end
      8: begin c.reg_write = 1; c.instr_done = 1; end
      9: begin
        c.pc_write_cond = 1; c.pc_source = 1; c.alu_src_a = 2'd1;
        c.alu_op = 2'b01; c.instr_done = 1;
      end
      10: begin
        c.pc_write = 1; c.pc_source = 1; c.reg_write = 1;
        c.mem_to_reg = 2'd2; c.instr_done = 1;
      end
      11: c.illegal = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock cycle: drive inputs, queue the expected state/control, advance.
  task automatic cyc(input int st, input bit rdy, input logic [6:0] opc, input bit rst);
    exp_t e;
    reset = rst;
    mem_ready = rdy;
    opcode = opc;
    e.st = 4'(st);
    e.ctl = rst ? ctl_t'('0) : exp_ctl(st, rdy);
    if (e.ctl.instr_done) exp_done++;
    if (e.ctl.illegal) exp_ill++;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  // Walk one instruction through its step list given fetch/memory stall counts.
  task automatic run_instr(input logic [6:0] opc, input int fst, input int mst);
    for (int i = 0; i < fst; i++) cyc(0, 1'b0, junk(), 1'b0);
    cyc(0, 1'b1, junk(), 1'b0);
    cyc(1, rbit(), opc, 1'b0);
    case (opc)
      OP_LOAD: begin
        cyc(2, rbit(), opc, 1'b0);
        for (int i = 0; i < mst; i++) cyc(3, 1'b0, junk(), 1'b0);
        cyc(3, 1'b1, junk(), 1'b0);
        cyc(4, rbit(), junk(), 1'b0);
      end
      OP_STORE: begin
        cyc(2, rbit(), opc, 1'b0);
        for (int i = 0; i < mst; i++) cyc(5, 1'b0, junk(), 1'b0);
        cyc(5, 1'b1, junk(), 1'b0);
      end
      OP_RTYPE: begin cyc(6, rbit(), junk(), 1'b0); cyc(8, rbit(), junk(), 1'b0); end
      OP_ITYPE: begin cyc(7, rbit(), junk(), 1'b0); cyc(8, rbit(), junk(), 1'b0); end
      OP_BRANCH: cyc(9, rbit(), junk(), 1'b0);
      OP_JAL:    cyc(10, rbit(), junk(), 1'b0);
      default:   cyc(11, rbit(), junk(), 1'b0);
    endcase
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o == OP_LOAD || o == OP_STORE || o == OP_RTYPE || o == OP_ITYPE ||
           o == OP_BRANCH || o == OP_JAL;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle that has a queued expectation is compared at negedge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      ctl_t a;
      e = sb.pop_front();
      a = '{PCWrite, PCWriteCond, PCSource, OldPCWrite, IorD, MemRead, MemWrite,
            IRWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, instr_done,
            illegal_instr};
      chk("state_dbg", int'(state_dbg), int'(e.st));
      chk("control_word", int'(a), int'(e.ctl));
      chk("memrd_memwr_exclusive", int'(MemRead & MemWrite), 0);
      chk("pcwr_pcwrcond_exclusive", int'(PCWrite & PCWriteCond), 0);
      if (instr_done === 1'b1) act_done++;
      if (illegal_instr === 1'b1) act_ill++;
    end
  end

  initial begin
    logic [6:0] legal_ops[6];
    logic [6:0] opc;
    legal_ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
    @(posedge clk);
    #1;
    // Reset held three cycles, then an R-type with mem_ready high.
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, junk(), 1'b1);
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_LOAD, 0, 2);
    run_instr(OP_STORE, 3, 0);
    run_instr(OP_BRANCH, 0, 0);
    run_instr(OP_JAL, 0, 0);
    run_instr(7'b1111111, 0, 0);
    run_instr(OP_ITYPE, 1, 0);
    // Reset asserted during a MEM_READ stall, held two edges, then normal fetch.
    cyc(0, 1'b1, junk(), 1'b0);
    cyc(1, 1'b1, OP_LOAD, 1'b0);
    cyc(2, 1'b1, OP_LOAD, 1'b0);
    cyc(3, 1'b0, junk(), 1'b0);
    cyc(3, 1'b0, junk(), 1'b1);
    cyc(0, 1'b0, junk(), 1'b1);
    run_instr(OP_RTYPE, 0, 0);
    // Randomized instruction stream with random stalls.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do opc = junk(); while (is_legal(opc));
      end else begin
        opc = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("instr_done_count", act_done, exp_done);
    chk("illegal_count", act_ill, exp_ill);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
